// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, built around a
// single-bit subtractor cell with a registered borrow. A start accepted in IDLE
// captures the operands. WIDTH RUN cycles follow, then a one-cycle DONE that
// publishes diff/borrow together with a done pulse.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  // Counter holds 0..WIDTH without wrapping inside one operation.
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   res_r;
  logic               bin_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   diff_r;
  logic               borrow_r;
  logic               busy_r;
  logic               done_r;
  logic               busy_nxt_s;
  logic               done_nxt_s;
  logic [1:0]         cell_s;
  logic               d_s;
  logic               bout_s;
  logic               last_bit_s;

  // Single-bit subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] sub_cell(input logic a0, input logic b0, input logic bin);
    logic d;
    logic bout;
    d    = a0 ^ b0 ^ bin;
    bout = (~a0 & b0) | (~(a0 ^ b0) & bin);
    return {bout, d};
  endfunction

  assign cell_s     = sub_cell(a_r[0], b_r[0], bin_r);
  assign d_s        = cell_s[0];
  assign bout_s     = cell_s[1];
  // The edge that processes the last bit is the one seen with cnt_r == WIDTH-1.
  assign last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; start is only looked at in IDLE, DONE always returns to IDLE.
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_bit_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so busy/done can be driven from flops.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (next_state_s)
      ST_IDLE: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
      ST_RUN: begin
        busy_nxt_s = 1'b1;
        done_nxt_s = 1'b0;
      end
      ST_DONE: begin
        busy_nxt_s = 1'b1;
        done_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  // Datapath: operand capture, per-bit shifting, and the result publish on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      res_r    <= {WIDTH{1'b0}};
      bin_r    <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      diff_r   <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            res_r <= {WIDTH{1'b0}};
            bin_r <= 1'b0;
            cnt_r <= {CNT_W{1'b0}};
          end else begin
            a_r   <= a_r;
            b_r   <= b_r;
          end
        end
        ST_RUN: begin
          a_r   <= {1'b0, a_r[WIDTH-1:1]};
          b_r   <= {1'b0, b_r[WIDTH-1:1]};
          res_r <= {d_s, res_r[WIDTH-1:1]};
          bin_r <= bout_s;
          cnt_r <= cnt_r + CNT_W'(1);
          // diff stays frozen during RUN; only the final shift is published.
          if (last_bit_s) begin
            diff_r   <= {d_s, res_r[WIDTH-1:1]};
            borrow_r <= bout_s;
          end else begin
            diff_r   <= diff_r;
            borrow_r <= borrow_r;
          end
        end
        ST_DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign diff   = diff_r;
  assign borrow = borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed corner cases,
// continuous start, mid-RUN reset and randomized operands against an
// arithmetic reference.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  int checks;
  int errors;
  int accepted;
  int done_cnt;

  // Reference state: the most recently published result.
  logic [WIDTH-1:0] exp_diff;
  logic             exp_borrow;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count done pulses.
  always @(posedge clk) begin
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One operation: capture, watch RUN, check latency and the published result.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input bit noise);
    int  n;
    bit  seen;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    accepted++;
    a = 8'($urandom);
    b = 8'($urandom);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      if (noise && n == 2) begin
        start = 1'b1;
        a = 8'($urandom);
      end
      if (done) begin
        seen = 1'b1;
      end else begin
        check("busy_run", 32'(busy), 32'd1);
        check("diff_hold", 32'(diff), 32'(exp_diff));
        @(posedge clk);
        #1;
        n++;
      end
    end
    start = 1'b0;
    check("latency", 32'(n), 32'(WIDTH));
    exp_diff   = av - bv;
    exp_borrow = (av < bv);
    check("busy_done", 32'(busy), 32'd1);
    check("diff", 32'(diff), 32'(exp_diff));
    check("borrow", 32'(borrow), 32'(exp_borrow));
    @(posedge clk);
    #1;
    check("done_low", 32'(done), 32'd0);
    check("busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    int ndone;
    int last;
    logic [7:0] ra;
    logic [7:0] rb;
    checks = 0;
    errors = 0;
    accepted = 0;
    done_cnt = 0;
    exp_diff = 8'h00;
    exp_borrow = 1'b0;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    rst_n = 1'b1;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases.
    run_op(8'h05, 8'h03, 1'b0);
    run_op(8'h03, 8'h05, 1'b0);
    run_op(8'h00, 8'h00, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'h00, 8'hFF, 1'b0);
    run_op(8'h05, 8'h03, 1'b1);

    // Start held high: one result every 10 cycles; a change mid-RUN is ignored.
    @(negedge clk);
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    ndone = 0;
    last = 0;
    for (int c = 1; c <= 60 && ndone < 3; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) a = 8'h20;
      if (done) begin
        ndone++;
        check("cont_diff", 32'(diff), 32'h0F);
        check("cont_borrow", 32'(borrow), 32'd0);
        if (ndone > 1) check("cont_period", 32'(c - last), 32'd10);
        last = c;
        a = 8'h10;
        if (ndone == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("cont_count", 32'(ndone), 32'd3);
    accepted += 3;
    exp_diff = 8'h0F;
    exp_borrow = 1'b0;
    repeat (2) @(posedge clk);

    // Reset in the middle of RUN abandons the operation.
    @(negedge clk);
    a = 8'h33;
    b = 8'h11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_diff", 32'(diff), 32'd0);
    check("mid_rst_borrow", 32'(borrow), 32'd0);
    exp_diff = 8'h00;
    exp_borrow = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("no_done_after_rst", 32'(ndone), 32'd0);
    run_op(8'h80, 8'h7F, 1'b0);

    // Randomized operands with random gaps and stray start pulses.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra, rb, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (2) @(posedge clk);
    check("done_count", 32'(done_cnt), 32'(accepted));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
